instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 129 ++++++++++++
 tb/tb_instruction_encoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// RV64I instruction encoder: packs R/LD/SD/BEQ field bundles into machine words
// and streams them with word addresses to an instruction memory writer.
module instruction_encoder #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        inValid,
    output logic        inReady,
    input  logic [1:0]  instrClass,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] immediate,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outInstruction,
    output logic [31:0] outAddress,
    output logic        done,
    output logic        error
);

    // One extra bit so the index can reach MEM_WORDS in FULL
    localparam int IW = $clog2(MEM_WORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        HOLD,
        FULL
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [31:0]   instr_q;
    logic [31:0]   addr_q;
    logic          done_q;
    logic          error_q;

    logic [31:0]   enc_d;
    logic          illegal_d;
    logic [IW-1:0] idx_inc_d;
    logic [31:0]   addr_d;

    always_comb begin
        enc_d     = '0;
        illegal_d = 1'b0;
        case (instrClass)
            2'b00: enc_d = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
            2'b01: begin
                enc_d     = {immediate[11:0], rs1, 3'b011, rd, 7'b0000011};
                illegal_d = immediate[12] ^ immediate[11];
            end
            2'b10: begin
                enc_d     = {immediate[11:5], rs2, rs1, 3'b011,
                             immediate[4:0], 7'b0100011};
                illegal_d = immediate[12] ^ immediate[11];
            end
            default: begin
                enc_d     = {immediate[12], immediate[10:5], rs2, rs1, 3'b000,
                             immediate[4:1], immediate[11], 7'b1100011};
                illegal_d = immediate[0];
            end
        endcase
        idx_inc_d = idx_q + 1'b1;
        addr_d    = 32'({idx_q, 2'b00});
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else if (start) begin
            state_q     <= ACCEPT;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                ACCEPT: begin
                    if (inValid) begin
                        instr_q     <= enc_d;
                        addr_q      <= addr_d;
                        error_q     <= error_q | illegal_d;
                        state_q     <= HOLD;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (outReady) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= idx_inc_d;
                        if (idx_inc_d == IW'(MEM_WORDS)) begin
                            state_q <= FULL;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ACCEPT;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                IDLE, FULL: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inReady        = in_ready_q;
    assign outValid       = out_valid_q;
    assign outInstruction = instr_q;
    assign outAddress     = addr_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed bench for instruction_encoder: vector table plus stall, full,
// reset-in-HOLD and start-priority sequences.
module tb_instruction_encoder;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        inValid;
    logic        inReady;
    logic [1:0]  instrClass;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] immediate;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstruction;
    logic [31:0] outAddress;
    logic        done;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;

    instruction_encoder #(.MEM_WORDS(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .inValid        (inValid),
        .inReady        (inReady),
        .instrClass     (instrClass),
        .funct7         (funct7),
        .funct3         (funct3),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .immediate      (immediate),
        .outValid       (outValid),
        .outReady       (outReady),
        .outInstruction (outInstruction),
        .outAddress     (outAddress),
        .done           (done),
        .error          (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        st;
        logic [1:0]  cls;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic [31:0] ins;
        logic [31:0] adr;
        logic        err;
    } vec_t;

    vec_t tv[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_fields(input logic [1:0] c, input logic [6:0] f7,
                              input logic [2:0] f3, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2,
                              input logic [12:0] im);
        instrClass = c;
        funct7     = f7;
        funct3     = f3;
        rd         = d;
        rs1        = s1;
        rs2        = s2;
        immediate  = im;
    endtask

    task automatic send();
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    task automatic handshake();
        outReady = 1'b1;
        tick();
        outReady = 1'b0;
    endtask

    logic [31:0] held_ins;
    logic [31:0] held_adr;

    initial begin
        tv[0] = '{1'b1, 2'b00, 7'h00, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0,
                  32'h002081B3, 32'h0, 1'b0};
        tv[1] = '{1'b1, 2'b01, 7'h7F, 3'd7, 5'd5, 5'd2, 5'd9, 13'd8,
                  32'h00813283, 32'h0, 1'b0};
        tv[2] = '{1'b0, 2'b10, 7'h00, 3'd0, 5'd0, 5'd2, 5'd5, 13'd16,
                  32'h00513823, 32'h4, 1'b0};
        tv[3] = '{1'b0, 2'b11, 7'h00, 3'd0, 5'd0, 5'd1, 5'd2, 13'h1FF8,
                  32'hFE208CE3, 32'h8, 1'b0};
        tv[4] = '{1'b1, 2'b11, 7'h00, 3'd0, 5'd0, 5'd1, 5'd2, 13'd5,
                  32'h00208263, 32'h0, 1'b1};
        tv[5] = '{1'b0, 2'b01, 7'h00, 3'd0, 5'd5, 5'd2, 5'd0, 13'd8,
                  32'h00813283, 32'h4, 1'b1};
        tv[6] = '{1'b1, 2'b01, 7'h00, 3'd0, 5'd5, 5'd2, 5'd0, 13'h0800,
                  32'h80013283, 32'h0, 1'b1};
        tv[7] = '{1'b0, 2'b00, 7'h20, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0,
                  32'h403100B3, 32'h4, 1'b1};
        tv[8] = '{1'b0, 2'b10, 7'h00, 3'd0, 5'd0, 5'd2, 5'd5, 13'h1FFC,
                  32'hFE513E23, 32'h8, 1'b1};
        tv[9] = '{1'b1, 2'b01, 7'h00, 3'd0, 5'd5, 5'd2, 5'd0, 13'h1000,
                  32'h00013283, 32'h0, 1'b1};

        reset    = 1'b1;
        start    = 1'b0;
        inValid  = 1'b0;
        outReady = 1'b0;
        set_fields(2'b00, 7'h0, 3'h0, 5'h0, 5'h0, 5'h0, 13'h0);
        #1;
        chk("rst_inReady", 32'(inReady), 32'h0);
        chk("rst_outValid", 32'(outValid), 32'h0);
        chk("rst_instr", outInstruction, 32'h0);
        chk("rst_addr", outAddress, 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // IDLE ignores bundles until start
        send();
        chk("idle_outValid", 32'(outValid), 32'h0);
        chk("idle_inReady", 32'(inReady), 32'h0);

        for (int i = 0; i < 10; i++) begin
            if (tv[i].st) begin
                do_start();
                chk($sformatf("v%0d_st_inReady", i), 32'(inReady), 32'h1);
                chk($sformatf("v%0d_st_err", i), 32'(error), 32'h0);
                chk($sformatf("v%0d_st_done", i), 32'(done), 32'h0);
            end
            set_fields(tv[i].cls, tv[i].f7, tv[i].f3, tv[i].rd,
                       tv[i].rs1, tv[i].rs2, tv[i].imm);
            send();
            chk($sformatf("v%0d_outValid", i), 32'(outValid), 32'h1);
            chk($sformatf("v%0d_inReady", i), 32'(inReady), 32'h0);
            chk($sformatf("v%0d_instr", i), outInstruction, tv[i].ins);
            chk($sformatf("v%0d_addr", i), outAddress, tv[i].adr);
            chk($sformatf("v%0d_error", i), 32'(error), 32'(tv[i].err));
            handshake();
            chk($sformatf("v%0d_hs_outValid", i), 32'(outValid), 32'h0);
        end

        // Stall in HOLD for 10 cycles
        do_start();
        set_fields(2'b00, 7'h00, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        send();
        held_ins = 32'h002081B3;
        held_adr = 32'h0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("stall%0d_outValid", c), 32'(outValid), 32'h1);
            chk($sformatf("stall%0d_inReady", c), 32'(inReady), 32'h0);
            chk($sformatf("stall%0d_instr", c), outInstruction, held_ins);
            chk($sformatf("stall%0d_addr", c), outAddress, held_adr);
        end
        handshake();
        send();
        chk("stall_next_addr", outAddress, 32'h4);
        handshake();

        // Fill all 4 words
        do_start();
        for (int w = 0; w < 4; w++) begin
            set_fields(2'b01, 7'h00, 3'd0, 5'(w + 1), 5'd2, 5'd0, 13'(w * 8));
            send();
            chk($sformatf("full_w%0d_addr", w), outAddress, 32'(w * 4));
            chk($sformatf("full_w%0d_instr", w), outInstruction,
                (32'(w * 8) << 20) | 32'h00013003 | (32'(w + 1) << 7));
            chk($sformatf("full_w%0d_done", w), 32'(done), 32'h0);
            handshake();
        end
        chk("full_done", 32'(done), 32'h1);
        chk("full_inReady", 32'(inReady), 32'h0);
        chk("full_outValid", 32'(outValid), 32'h0);
        inValid = 1'b1;
        tick();
        tick();
        inValid = 1'b0;
        chk("full_ignore_outValid", 32'(outValid), 32'h0);
        chk("full_ignore_done", 32'(done), 32'h1);
        do_start();
        chk("full_restart_done", 32'(done), 32'h0);
        chk("full_restart_inReady", 32'(inReady), 32'h1);
        set_fields(2'b00, 7'h00, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        send();
        chk("full_restart_addr", outAddress, 32'h0);
        handshake();

        // Reset asserted while a word is held
        do_start();
        set_fields(2'b11, 7'h00, 3'd0, 5'd0, 5'd1, 5'd2, 13'd5);
        send();
        chk("rh_pre_outValid", 32'(outValid), 32'h1);
        chk("rh_pre_error", 32'(error), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rh_outValid", 32'(outValid), 32'h0);
        chk("rh_instr", outInstruction, 32'h0);
        chk("rh_addr", outAddress, 32'h0);
        chk("rh_error", 32'(error), 32'h0);
        chk("rh_inReady", 32'(inReady), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("rh_idle_inReady", 32'(inReady), 32'h0);
        set_fields(2'b00, 7'h00, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
        start   = 1'b1;
        inValid = 1'b1;
        tick();
        start = 1'b0;
        chk("rh_start_outValid", 32'(outValid), 32'h0);
        chk("rh_start_inReady", 32'(inReady), 32'h1);
        tick();
        inValid = 1'b0;
        chk("rh_cap_outValid", 32'(outValid), 32'h1);
        chk("rh_cap_instr", outInstruction, 32'h002081B3);
        chk("rh_cap_addr", outAddress, 32'h0);

        // start beats a simultaneous handshake in HOLD
        handshake();
        send();
        chk("sp_pre_addr", outAddress, 32'h4);
        start    = 1'b1;
        outReady = 1'b1;
        tick();
        start    = 1'b0;
        outReady = 1'b0;
        chk("sp_outValid", 32'(outValid), 32'h0);
        chk("sp_inReady", 32'(inReady), 32'h1);
        send();
        chk("sp_next_addr", outAddress, 32'h0);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
